mem_port_arbiter: RTL

//  Parametrised N-channel memory-port arbiter: merges NUM_CH master request/response channel pairs
//  (e.g. core fetch + load/store) onto one external memory port of the same request/response form.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_id_fifo.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the memory-port arbiter
package mem_arb_pkg;

    // Kind of a registered downstream request; encoding matches the m_write pin.
    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_kind_e;

    // Width of a channel index; at least one bit so the ID FIFO always has a field.
    function automatic int ch_w(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

    // Round-robin successor of a channel index.
    function automatic int rr_next(input int ptr, input int num_ch);
        return (ptr + 1 >= num_ch) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// rtl/mem_arb_id_fifo.sv - FIFO of channel IDs for reads awaiting a response
module mem_arb_id_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 1,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Entry storage; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin merge of request/response channels onto one memory port
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int NUM_CH    = 2,
    parameter int MAX_OUTST = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH*ADDR_W-1:0] ch_m_address,
    input  logic [NUM_CH*DATA_W-1:0] ch_m_data,
    input  logic [NUM_CH-1:0]        ch_m_write,
    input  logic [NUM_CH-1:0]        ch_m_valid,
    output logic [NUM_CH-1:0]        ch_m_ready,
    output logic [NUM_CH*DATA_W-1:0] ch_s_data,
    output logic [NUM_CH-1:0]        ch_s_valid,
    input  logic [NUM_CH-1:0]        ch_s_ready,
    output logic [ADDR_W-1:0]        m_address,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_write,
    output logic                     m_valid,
    input  logic                     m_ready,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     err_orphan
);

    localparam int CH_W  = ch_w(NUM_CH);
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;

    typedef logic [CH_W-1:0] ch_id_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        req_kind_e         kind;
    } req_t;

    req_t        req_q, req_d;
    logic        m_valid_q, m_valid_d;
    ch_id_t      rr_q, rr_d;
    logic        err_q, err_d;

    logic [NUM_CH-1:0] eligible;
    logic              gnt_found;
    ch_id_t            gnt_id;
    int                scan_idx;
    logic              slot_free;
    logic              accept;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    ch_id_t            fifo_head;
    logic [CNT_W-1:0]  fifo_cnt;

    assign slot_free = !m_valid_q || m_ready;
    assign accept    = gnt_found && slot_free;

    // Round-robin pick: first eligible channel at or after the rr pointer.
    // Read eligibility looks only at the registered count, so a response
    // popping this cycle never frees a slot for a read in the same cycle.
    always_comb begin
        eligible  = '0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan_idx  = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            eligible[i] = ch_m_valid[i] && (ch_m_write[i] || fifo_cnt < CNT_W'(MAX_OUTST));
        end
        for (int k = 0; k < NUM_CH; k++) begin
            scan_idx = int'(rr_q) + k;
            if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
            if (!gnt_found && eligible[ch_id_t'(scan_idx)]) begin
                gnt_found = 1'b1;
                gnt_id    = ch_id_t'(scan_idx);
            end
        end
    end

    // Upstream ready is one-hot to the granted channel, only when the output slot can take it.
    always_comb begin
        ch_m_ready = '0;
        if (accept) ch_m_ready[gnt_id] = 1'b1;
    end

    // Next state of the request register and rr pointer.
    always_comb begin
        req_d     = req_q;
        m_valid_d = m_valid_q;
        rr_d      = rr_q;
        if (accept) begin
            req_d.addr = ch_m_address[int'(gnt_id)*ADDR_W +: ADDR_W];
            req_d.data = ch_m_data[int'(gnt_id)*DATA_W +: DATA_W];
            req_d.kind = req_kind_e'(ch_m_write[gnt_id]);
            m_valid_d  = 1'b1;
            rr_d       = ch_id_t'(rr_next(int'(gnt_id), NUM_CH));
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // Response demux: route to the oldest outstanding reader, swallow orphans.
    always_comb begin
        ch_s_valid = '0;
        s_ready    = 1'b1;
        fifo_pop   = 1'b0;
        err_d      = err_q;
        if (!fifo_empty) begin
            ch_s_valid[fifo_head] = s_valid;
            s_ready               = ch_s_ready[fifo_head];
            fifo_pop              = s_valid && ch_s_ready[fifo_head];
        end else if (s_valid) begin
            err_d = 1'b1;
        end
    end

    // Request register, rr pointer and sticky orphan flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_q     <= '0;
            m_valid_q <= 1'b0;
            rr_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            req_q     <= req_d;
            m_valid_q <= m_valid_d;
            rr_q      <= rr_d;
            err_q     <= err_d;
        end
    end

    // Only reads expect a response; full is already excluded by eligibility.
    assign fifo_push = accept && !ch_m_write[gnt_id] && !fifo_full;

    mem_arb_id_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (CH_W)
    ) u_id_fifo (
        .clk_i       (clock),
        .rst_ni      (reset),
        .push_i      (fifo_push),
        .push_data_i (gnt_id),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head),
        .count_o     (fifo_cnt)
    );

    assign m_address  = req_q.addr;
    assign m_data     = req_q.data;
    assign m_write    = (req_q.kind == REQ_WRITE);
    assign m_valid    = m_valid_q;
    assign ch_s_data  = {NUM_CH{s_data}};
    assign err_orphan = err_q;

endmodule
